// File: rtl/po_input_array_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the input-array read-port arbiter.
package po_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = $clog2(MAX_REQ);

  typedef struct packed {
    logic               valid;
    logic [MAX_REQ-1:0] onehot;
  } tag_t;

  // Requests above NUM_REQ are zero, so scanning modulo MAX_REQ gives the
  // same winner as scanning modulo NUM_REQ.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [PTR_W-1:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/po_input_array_arbiter_if.sv
// Requester/RAM bundle of the input-array arbiter; test port exists only with PO_ARB_TEST_PORT_EN.
interface po_input_array_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 64
);

  logic                      en_i;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [ADDR_W-1:0]         ram_addr_o;
  logic                      ram_rden_o;
  logic [DATA_W-1:0]         ram_q_i;
  logic [DATA_W-1:0]         rdata_o;
  logic [NUM_REQ-1:0]        rvalid_o;
  logic                      busy_o;
`ifdef PO_ARB_TEST_PORT_EN
  logic                      test_sel_i;
  logic [ADDR_W-1:0]         test_addr_i;
  logic                      test_rvalid_o;
`endif

  modport slave (
    input  en_i, req_i, addr_i, ram_q_i,
`ifdef PO_ARB_TEST_PORT_EN
    input  test_sel_i, test_addr_i,
    output test_rvalid_o,
`endif
    output gnt_o, ram_addr_o, ram_rden_o, rdata_o, rvalid_o, busy_o
  );

  modport master (
    output en_i, req_i, addr_i, ram_q_i,
`ifdef PO_ARB_TEST_PORT_EN
    output test_sel_i, test_addr_i,
    input  test_rvalid_o,
`endif
    input  gnt_o, ram_addr_o, ram_rden_o, rdata_o, rvalid_o, busy_o
  );

endinterface

// File: rtl/po_input_array_arbiter_tag_pipe.sv
// RD_LATENCY-deep shift register of return tags; busy reflects any valid stage.
module po_arb_tag_pipe
  import po_arb_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  tag_t din,
  output tag_t dout,
  output logic busy
);

  tag_t stage [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) busy = busy | stage[i].valid;
  end

  assign dout = stage[RD_LATENCY-1];

endmodule

// File: rtl/po_input_array_arbiter.sv
// Round-robin arbiter for the single read port of the input-array RAM.
// Define PO_ARB_TEST_PORT_EN to add the priority test read port.
module po_input_array_arbiter
  import po_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 2
) (
  input logic                  clk,
  input logic                  reset,
  po_input_array_arbiter_if.slave bus
);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]  addr_shadow_q, addr_sel;
  logic [MAX_REQ-1:0] req_pad, pick;
  logic [NUM_REQ-1:0] gnt;
  logic               arb_issue, test_issue, rden;
  tag_t               tag_in, tag_out;
  logic               pipe_busy;
  logic               unused_bits;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = bus.req_i;
    pick                   = rr_pick(req_pad, ptr_q);
    test_issue             = 1'b0;
`ifdef PO_ARB_TEST_PORT_EN
    test_issue             = bus.test_sel_i & reset;
`endif
    // Everything is gated by reset so nothing issues while it is held low.
    arb_issue = reset & bus.en_i & (|bus.req_i) & ~test_issue;
    gnt       = arb_issue ? pick[NUM_REQ-1:0] : '0;
    addr_sel  = addr_shadow_q;
    ptr_d     = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        addr_sel = bus.addr_i[k*ADDR_W +: ADDR_W];
        ptr_d    = (k == NUM_REQ-1) ? '0 : PTR_W'(k+1);
      end
    end
`ifdef PO_ARB_TEST_PORT_EN
    if (test_issue) addr_sel = bus.test_addr_i;
`endif
    rden                        = arb_issue | test_issue;
    tag_in                      = '0;
    tag_in.valid                = rden;
    tag_in.onehot[NUM_REQ-1:0]  = gnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q         <= '0;
      addr_shadow_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (rden) addr_shadow_q <= addr_sel;
    end
  end

  po_arb_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .rst_b(reset),
    .din  (tag_in),
    .dout (tag_out),
    .busy (pipe_busy)
  );

  assign bus.gnt_o      = gnt;
  assign bus.ram_addr_o = addr_sel;
  assign bus.ram_rden_o = rden;
  assign bus.rdata_o    = bus.ram_q_i;
  assign bus.rvalid_o   = tag_out.valid ? tag_out.onehot[NUM_REQ-1:0] : '0;
  assign bus.busy_o     = pipe_busy;
`ifdef PO_ARB_TEST_PORT_EN
  // A test read is the only valid tag carrying no requester bit.
  assign bus.test_rvalid_o = tag_out.valid & ~(|tag_out.onehot);
`endif

  // Request/tag bits above NUM_REQ are structurally zero.
  assign unused_bits = ^{pick, tag_out.onehot};

endmodule

// File: tb/tb_po_input_array_arbiter.sv
// Self-checking bench for po_input_array_arbiter: table vectors, corner sequences, random vs. model.
module tb_po_input_array_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 9;
  localparam int DW  = 64;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  po_input_array_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  po_input_array_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // RAM with a fixed two-cycle read latency
  logic [DW-1:0] mem [512];
  logic [DW-1:0] q1;
  always @(posedge clk) begin
    q1          <= mem[bus.ram_addr_o];
    bus.ram_q_i <= q1;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int            due;
    int            who;   // -1 marks a test-port read
    logic [DW-1:0] data;
  } ret_t;

  ret_t        inflight[$];
  int          m_ptr;
  logic [AW-1:0] m_last_addr;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] exp_gnt;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare all outputs to the model, then advance the model at the edge.
  task automatic step();
    int            win;
    logic          tsel;
    logic [AW-1:0] taddr;
    logic [3:0]    eg;
    logic [3:0]    erv;
    logic          etv;
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    logic          issued;
    #1;
    if (!reset) begin
      inflight.delete();
      m_ptr       = 0;
      m_last_addr = '0;
    end
    tsel  = 1'b0;
    taddr = '0;
`ifdef PO_ARB_TEST_PORT_EN
    tsel  = bus.test_sel_i;
    taddr = bus.test_addr_i;
`endif
    win = -1;
    if (reset && !tsel && bus.en_i) begin
      for (int i = 0; i < NR; i++) begin
        int j;
        j = (m_ptr + i) % NR;
        if (win < 0 && bus.req_i[j]) win = j;
      end
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    issued = (win >= 0) || (reset && tsel);
    if (win >= 0)          ea = bus.addr_i[win*AW +: AW];
    else if (reset && tsel) ea = taddr;
    else                    ea = m_last_addr;
    erv = '0; etv = 1'b0; ed = '0;
    foreach (inflight[i]) begin
      if (inflight[i].due == cyc) begin
        if (inflight[i].who >= 0) erv[inflight[i].who] = 1'b1;
        else                      etv = 1'b1;
        ed = inflight[i].data;
      end
    end
    chk("gnt",      64'(bus.gnt_o),      64'(eg));
    chk("rden",     64'(bus.ram_rden_o), 64'(issued));
    chk("ram_addr", 64'(bus.ram_addr_o), 64'(ea));
    chk("rvalid",   64'(bus.rvalid_o),   64'(erv));
    chk("busy",     64'(bus.busy_o),     64'(inflight.size() != 0));
`ifdef PO_ARB_TEST_PORT_EN
    chk("test_rvalid", 64'(bus.test_rvalid_o), 64'(etv));
`endif
    if (erv != 0 || etv) chk("rdata", bus.rdata_o, ed);
    @(posedge clk);
    for (int i = inflight.size() - 1; i >= 0; i--)
      if (inflight[i].due == cyc) inflight.delete(i);
    if (issued) begin
      inflight.push_back('{cyc + LAT, win, mem[ea]});
      m_last_addr = ea;
      if (win >= 0) m_ptr = (win + 1) % NR;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_addrs(input int a0, input int a1, input int a2, input int a3);
    bus.addr_i = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {32'(i * 7 + 1), 32'hC0DE_0000 | 32'(i)};
    mem[5] = 64'h123;

    tbl[0]  = '{1'b1, 4'b0001, 4'b0001};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0010};
    tbl[2]  = '{1'b1, 4'b0011, 4'b0001};
    tbl[3]  = '{1'b1, 4'b0011, 4'b0010};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0000};
    tbl[5]  = '{1'b1, 4'b1000, 4'b1000};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[8]  = '{1'b1, 4'b1111, 4'b0010};
    tbl[9]  = '{1'b1, 4'b1111, 4'b0100};
    tbl[10] = '{1'b1, 4'b1111, 4'b1000};
    tbl[11] = '{1'b1, 4'b1111, 4'b0001};
    tbl[12] = '{1'b1, 4'b0100, 4'b0100};
    tbl[13] = '{1'b1, 4'b0110, 4'b0010};

    reset      = 1'b0;
    bus.en_i   = 1'b0;
    bus.req_i  = '0;
    bus.addr_i = '0;
`ifdef PO_ARB_TEST_PORT_EN
    bus.test_sel_i  = 1'b0;
    bus.test_addr_i = '0;
`endif
    @(negedge clk);
    #1;
    chk("reset_gnt",    64'(bus.gnt_o),      64'd0);
    chk("reset_rden",   64'(bus.ram_rden_o), 64'd0);
    chk("reset_addr",   64'(bus.ram_addr_o), 64'd0);
    chk("reset_rvalid", 64'(bus.rvalid_o),   64'd0);
    chk("reset_busy",   64'(bus.busy_o),     64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single request, two-cycle return
    bus.en_i = 1'b1;
    set_addrs(5, 0, 0, 0);
    bus.req_i = 4'b0001;
    step();
    bus.req_i = 4'b0000;
    step();
    step();

    // Table: grants from a freshly reset pointer
    pulse_reset();
    set_addrs(10, 20, 30, 40);
    for (int r = 0; r < 14; r++) begin
      bus.en_i  = tbl[r].en;
      bus.req_i = tbl[r].req;
      #1;
      chk($sformatf("tbl%0d_gnt", r), 64'(bus.gnt_o), 64'(tbl[r].exp_gnt));
      for (int k = 0; k < NR; k++)
        if (tbl[r].exp_gnt[k]) chk($sformatf("tbl%0d_addr", r), 64'(bus.ram_addr_o), 64'(10 * (k + 1)));
      step();
    end
    bus.req_i = '0;
    step(); step();

    // en_i drops with two reads in flight
    bus.en_i  = 1'b1;
    bus.req_i = 4'b1111;
    step(); step();
    bus.en_i = 1'b0;
    step(); step();
    #1;
    chk("en_off_busy_low", 64'(bus.busy_o), 64'd0);
    step();

    // Reset with reads in flight: they never return, pointer restarts at 0
    bus.en_i  = 1'b1;
    bus.req_i = 4'b0110;
    step(); step();
    bus.req_i = '0;
    pulse_reset();
    step(); step();
    bus.req_i = 4'b1111;
    #1;
    chk("post_reset_gnt", 64'(bus.gnt_o), 64'b0001);
    step();
    bus.req_i = '0;
    step(); step();

`ifdef PO_ARB_TEST_PORT_EN
    // Test port overrides arbitration
    bus.req_i       = 4'b1111;
    bus.test_sel_i  = 1'b1;
    bus.test_addr_i = '0;
    #1;
    chk("test_gnt_suppressed", 64'(bus.gnt_o), 64'd0);
    step();
    bus.test_sel_i = 1'b0;
    bus.req_i      = '0;
    step();
    #1;
    chk("test_rvalid_pulse", 64'(bus.test_rvalid_o), 64'd1);
    chk("test_rdata",        bus.rdata_o,            mem[0]);
    step();
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus.en_i   = ($urandom_range(0, 7) != 0);
      bus.req_i  = 4'($urandom_range(0, 15));
      bus.addr_i = 36'({$urandom, $urandom});
`ifdef PO_ARB_TEST_PORT_EN
      bus.test_sel_i  = ($urandom_range(0, 7) == 0);
      bus.test_addr_i = 9'($urandom);
`endif
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step();
    end
    bus.req_i = '0;
`ifdef PO_ARB_TEST_PORT_EN
    bus.test_sel_i = 1'b0;
`endif
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/po_input_array_arbiter.md
Name: po_input_array_arbiter

Overview:
Round-robin arbiter sharing the single read port of the input-array RAM (the cone-data store loaded from data<N>.hex) between NUM_REQ datapath requesters (cone evaluators, q_hat/q_trans loops, readout).
- Sits between the po_fpga datapath clients and the RAM.
- Issues at most one read per cycle and routes each returned word back to its requester with a valid strobe, accounting for the RAM's fixed read latency.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 9, RAM address width
DATA_W, 64, RAM word width (signed data, passed through untouched)
RD_LATENCY, 2, cycles from ram_rden_o to valid ram_q_i (1..4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
en_i  in  1  arbitration enable from control unit; 0 = issue no new grants
req_i  in  NUM_REQ  per-requester read request, level, held until granted
addr_i  in  NUM_REQ*ADDR_W  packed request addresses, slice k = requester k
gnt_o  out  NUM_REQ  one-hot grant, combinational, same cycle as issue
ram_addr_o  out  ADDR_W  RAM read address
ram_rden_o  out  1  RAM read enable
ram_q_i  in  DATA_W  RAM read data
rdata_o  out  DATA_W  returned data, broadcast to all requesters
rvalid_o  out  NUM_REQ  one-hot: rdata_o belongs to requester k this cycle
busy_o  out  1  any read in flight

Behaviour:
- Reset (reset=0, asynchronous): RR pointer=0; tag pipeline cleared; rvalid_o=0, busy_o=0. gnt_o, ram_rden_o and ram_addr_o are 0 while reset is asserted. In-flight reads are dropped with no rvalid.
- Arbitration, cycle t, only when en_i=1 and |req_i:
  - Winner k = first requester with req_i set, scanning from pointer upward with wrap NUM_REQ-1 -> 0.
  - gnt_o[k]=1, ram_rden_o=1, ram_addr_o=addr_i slice k, all combinational in cycle t.
  - Pointer <= (k+1) mod NUM_REQ at the next clk edge.
- No request or en_i=0: gnt_o=0, ram_rden_o=0, ram_addr_o holds its last issued value (registered shadow, 0 after reset). Pointer unchanged.
- Requester contract:
  - Holds req_i and its address until it sees gnt_o.
  - Dropping req_i before grant is legal and no read is issued.
  - A requester may re-request the cycle after its grant; back-to-back reads from different requesters are permitted every cycle.
- Return path:
  - Tag pipeline RD_LATENCY deep carries a one-hot tag + valid bit.
  - Read issued at t gives rvalid_o[k]=1 and rdata_o=ram_q_i at t+RD_LATENCY, exactly one cycle wide.
  - rdata_o is combinational from ram_q_i; content is undefined when rvalid_o=0.
- busy_o = OR of tag-pipeline valid bits.
- Throughput: 1 read/cycle sustained. Fairness: with all NUM_REQ requesting, each requester is granted exactly once per NUM_REQ cycles.
- en_i falling mid-stream: no new grants; reads already issued still return.
- Simultaneous grant and return for the same requester in one cycle is legal.

Optional Feature:
PO_ARB_TEST_PORT_EN
- With the macro: extra inputs test_sel_i (1) and test_addr_i (ADDR_W), plus extra output test_rvalid_o (1).
  - test_sel_i=1 has absolute priority, ignores en_i, and suppresses all gnt_o.
  - The read is issued from test_addr_i; test_rvalid_o pulses RD_LATENCY cycles later.
  - The pointer does not advance.
  - Used by benches for readout of input_array contents.
- Without the macro: these ports do not exist and test logic is absent.

Decomposition:
- Package po_arb_pkg holds:
  - localparam MAX_REQ=8
  - function rr_pick(req, ptr) returning a one-hot vector
  - typedef for the tag entry {valid, onehot}
- One sub-module, po_arb_tag_pipe: a parameterised RD_LATENCY-stage shift register of tag entries with asynchronous active-low clear.

Test Plan:
- Single request: req_i=0001, addr0=0x05, RAM preloaded mem[5]=0x123 -> gnt_o=0001 and ram_addr_o=5 in the same cycle; rvalid_o=0001, rdata_o=0x123 exactly 2 cycles later.
- All four requesting continuously, pointer=0 -> grants 0001, 0010, 0100, 1000, 0001... on consecutive cycles; each rvalid_o delayed by 2 and matching addresses 10, 20, 30, 40.
- Pointer=2, req_i=0011 -> gnt_o=0001 (wrap); pointer becomes 1 -> next grant 0010.
- en_i=0 while req_i=1111 with 2 reads in flight -> no gnt_o; both rvalid_o still arrive; busy_o falls after the last one.
- reset pulsed low for 1 cycle with 2 reads in flight -> rvalid_o never asserts for them; after release, the first grant goes to requester 0.
- PO_ARB_TEST_PORT_EN, test_sel_i=1, test_addr_i=0 with req_i=1111 -> gnt_o=0000; test_rvalid_o pulses 2 cycles later with mem[0].
